// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jam_pkg
// Brief    : Shared sizes, FSM state encoding and list helper for jam_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package jam_pkg;

  localparam int NUM_WORK = 8;
  localparam int IDX_W    = 3;
  localparam int COST_W   = 7;
  localparam int SUM_W    = 10;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;
  localparam int LIST_W   = NUM_WORK * IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Plain-vector aliases so the state register stays a legacy 3-bit vector
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_REQ   = ST_REQ;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_DONE  = ST_DONE;

  // Job assigned to worker idx; a constant-index mux, no index arithmetic
  function automatic logic [IDX_W-1:0] job_of(input logic [LIST_W-1:0] list,
                                              input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] w_job;
    w_job = '0;
    for (int k = 0; k < NUM_WORK; k++) begin
      if (idx == IDX_W'(k)) w_job = list[k*IDX_W +: IDX_W];
    end
    return w_job;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jam_cost_acc.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_acc
// Brief    : Per-permutation cost accumulator, prune comparator, best/count.
// Revision : 1.0 - initial release
// ============================================================================
module jam_cost_acc
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_clr,
  input  logic              i_acc_en,
  input  logic [COST_W-1:0] i_match_cost,
  input  logic              i_commit,
  output logic              o_prune,
  output logic [SUM_W-1:0]  o_best,
  output logic [CNT_W-1:0]  o_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CNT_MAX);

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] r_best;
  logic [CNT_W-1:0] r_count;
  logic             r_min_seen;
  logic [SUM_W-1:0] w_sum_next;

  assign w_sum_next = r_sum + SUM_W'(i_match_cost);

  // Costs are non-negative, so once the partial sum passes best it never recovers
  assign o_prune = i_acc_en && r_min_seen && (w_sum_next > r_best);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sum      <= '0;
      r_best     <= '0;
      r_count    <= '0;
      r_min_seen <= 1'b0;
    end else begin
      if (i_clr) begin
        r_sum <= '0;
      end else if (i_acc_en) begin
        r_sum <= w_sum_next;
      end

      if (i_commit) begin
        if (!r_min_seen || (r_sum < r_best)) begin
          r_best     <= r_sum;
          r_count    <= c_cnt_one;
          r_min_seen <= 1'b1;
        end else if ((r_sum == r_best) && (r_count != c_cnt_max)) begin
          r_count <= r_count + c_cnt_one;
        end
      end
    end
  end

  assign o_best  = r_best;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/jam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jam_ctrl
// Brief    : Exhaustive job-assignment search over engine-supplied permutations.
// Revision : 1.0 - initial release
// ============================================================================
module jam_ctrl
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  output logic              perm_next,
  input  logic              perm_valid,
  input  logic [LIST_W-1:0] perm_list,
  input  logic              perm_last,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] MatchCost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);

  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_WORK - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_w;
  logic [IDX_W-1:0]  r_j;
  logic [LIST_W-1:0] r_list;
  logic              r_last;
  logic              r_fetch_d;
  logic              r_abort;
  logic              r_valid;
  logic              w_take;
  logic              w_fetch;
  logic              w_acc_en;
  logic              w_commit;
  logic              w_prune;

  assign w_take   = (r_state == S_WAIT) && perm_valid;
  assign w_fetch  = (r_state == S_FETCH);
  // ROM answers one cycle after a fetch; once pruned to CHECK it is dropped
  assign w_acc_en = r_fetch_d && ((r_state == S_FETCH) || (r_state == S_DRAIN));
  assign w_commit = (r_state == S_CHECK) && !r_abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (perm_valid) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_prune)                  w_state_nxt = S_CHECK;
        else if (r_idx == c_idx_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = r_last ? S_DONE : S_REQ;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_w       <= '0;
      r_j       <= '0;
      r_list    <= '0;
      r_last    <= 1'b0;
      r_fetch_d <= 1'b0;
      r_abort   <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fetch_d <= w_fetch;
      r_w       <= W;
      r_j       <= J;
      r_valid   <= (r_state == S_CHECK) && r_last;

      if (w_take) begin
        r_list <= perm_list;
        r_last <= perm_last;
        r_idx  <= '0;
      end else if (w_fetch) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_prune) begin
        r_abort <= 1'b1;
      end else if (r_state == S_CHECK) begin
        r_abort <= 1'b0;
      end
    end
  end

  // W/J follow idx during FETCH and otherwise hold the last pair driven
  assign W         = w_fetch ? r_idx : r_w;
  assign J         = w_fetch ? job_of(r_list, r_idx) : r_j;
  assign perm_next = (r_state == S_REQ);
  assign Valid     = r_valid;

  jam_cost_acc u_cost_acc (
    .CLK          (CLK),
    .RST          (RST),
    .i_clr        (w_take),
    .i_acc_en     (w_acc_en),
    .i_match_cost (MatchCost),
    .i_commit     (w_commit),
    .o_prune      (w_prune),
    .o_best       (MinCost),
    .o_count      (MatchCount)
  );

endmodule
`default_nettype wire

// File: tb/tb_jam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_ctrl
// Brief    : Self-checking bench for jam_ctrl with permutation engine and ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jam_ctrl;
  import jam_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        perm_next;
  logic        perm_valid = 1'b0;
  logic [23:0] perm_list  = '0;
  logic        perm_last  = 1'b0;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  MatchCost = '0;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          rom [8][8];
  logic [23:0] seq [$];

  always #5 CLK = ~CLK;

  // Registered cost ROM: answer appears the cycle after W/J
  always @(posedge CLK) MatchCost <= 7'(rom[W][J]);

  jam_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .perm_next  (perm_next),
    .perm_valid (perm_valid),
    .perm_list  (perm_list),
    .perm_last  (perm_last),
    .W          (W),
    .J          (J),
    .MatchCost  (MatchCost),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int job(input logic [23:0] p, input int k);
    return int'(p[3*k +: 3]);
  endfunction

  function automatic logic [23:0] ident();
    logic [23:0] p;
    for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(k);
    return p;
  endfunction

  function automatic logic [23:0] swap01();
    logic [23:0] p;
    p = ident();
    p[2:0] = 3'd1;
    p[5:3] = 3'd0;
    return p;
  endfunction

  function automatic logic [23:0] rand_perm();
    int a [8];
    int j, t;
    logic [23:0] p;
    for (int k = 0; k < 8; k++) a[k] = k;
    for (int k = 7; k > 0; k--) begin
      j = int'($urandom_range(0, k));
      t = a[k]; a[k] = a[j]; a[j] = t;
    end
    for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(a[k]);
    return p;
  endfunction

  // kind: 0 diagonal, 1 all-zero, 2 prune, 3 tie, 4 random
  task automatic set_rom(input int kind);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        case (kind)
          0: rom[w][j] = (w == j) ? 1 : 100;
          1: rom[w][j] = 0;
          2: rom[w][j] = (w == j) ? 0 : 127;
          3: begin
            if (w == j)           rom[w][j] = (w < 2) ? 4 : 2;
            else if (w < 2 && j < 2) rom[w][j] = 4;
            else                  rom[w][j] = 100;
          end
          default: rom[w][j] = int'($urandom_range(0, 127));
        endcase
  endtask

  task automatic rand_seq(input int n);
    seq.delete();
    for (int i = 0; i < n; i++) seq.push_back(rand_perm());
  endtask

  task automatic insert_rand(input logic [23:0] p);
    seq.insert(int'($urandom_range(0, seq.size())), p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_perm_next"},  32'(perm_next),  0);
    chk({tag, "_W"},          32'(W),          0);
    chk({tag, "_J"},          32'(J),          0);
    chk({tag, "_MinCost"},    32'(MinCost),    0);
    chk({tag, "_MatchCount"}, 32'(MatchCount), 0);
    chk({tag, "_Valid"},      32'(Valid),      0);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1; perm_valid = 1'b0; perm_last = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_vals(tag);
    RST = 1'b0;
  endtask

  // Plays the permutation engine over seq and checks against a search model.
  // Gap = cycles from the accepted perm_valid to the next perm_next/Valid:
  // 8 fetches + drain + check + 1 = 11, or k+4 when worker k's add prunes.
  task automatic run(input string tag, input int stall, input bit spur, input int rst_perm);
    int     m_best, m_cnt, s, k_ab, gap, nf, t, cnt, d, extra;
    bit     m_seen;
    m_best = 0; m_cnt = 0; m_seen = 0;
    for (int p = 0; p < seq.size(); p++) begin
      t = 0;
      while (perm_next !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
      chk($sformatf("%s_req_p%0d", tag, p), 32'(perm_next), 1);
      if (perm_next !== 1'b1) return;
      d = stall ? int'($urandom_range(0, 5)) : 0;
      repeat (1 + d) begin
        @(negedge CLK);
        chk($sformatf("%s_next_low_p%0d", tag, p), 32'(perm_next), 0);
      end
      perm_list  = seq[p];
      perm_last  = (p == seq.size() - 1);
      perm_valid = 1'b1;

      s = 0; k_ab = -1;
      for (int w = 0; w < 8; w++) begin
        s += rom[w][job(seq[p], w)];
        if (m_seen && s > m_best && k_ab < 0) k_ab = w;
      end
      gap = (k_ab < 0) ? 11 : k_ab + 4;
      nf  = (k_ab < 0) ? 8 : ((k_ab + 2 > 8) ? 8 : k_ab + 2);
      if (k_ab < 0) begin
        if (!m_seen || s < m_best) begin m_best = s; m_cnt = 1; m_seen = 1; end
        else if (s == m_best && m_cnt < 15) m_cnt++;
      end

      cnt = 0;
      do begin
        @(negedge CLK); cnt++;
        if (cnt == 1 && spur) begin
          perm_valid = 1'b1; perm_last = 1'b1; perm_list = 24'($urandom);
        end else begin
          perm_valid = 1'b0; perm_last = 1'b0;
        end
        if (cnt <= nf) begin
          chk($sformatf("%s_W_p%0d_c%0d", tag, p, cnt), 32'(W), 32'(cnt - 1));
          chk($sformatf("%s_J_p%0d_c%0d", tag, p, cnt), 32'(J), 32'(job(seq[p], cnt - 1)));
        end
        if (p == rst_perm && cnt == 2) begin
          RST = 1'b1; perm_valid = 1'b0; perm_last = 1'b0;
          @(negedge CLK);
          check_reset_vals({tag, "_midfetch_rst"});
          RST = 1'b0;
          return;
        end
      end while (perm_next !== 1'b1 && Valid !== 1'b1 && cnt < 40);
      chk($sformatf("%s_gap_p%0d", tag, p), 32'(cnt), 32'(gap));
    end

    chk({tag, "_valid"},      32'(Valid),      1);
    chk({tag, "_MinCost"},    32'(MinCost),    32'(m_best));
    chk({tag, "_MatchCount"}, 32'(MatchCount), 32'(m_cnt));
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      perm_valid = (i % 3 == 0); perm_last = 1'b1; perm_list = rand_perm();
      if (Valid === 1'b1 || perm_next === 1'b1) extra++;
    end
    perm_valid = 1'b0; perm_last = 1'b0;
    chk({tag, "_done_quiet"},      32'(extra),      0);
    chk({tag, "_done_MinCost"},    32'(MinCost),    32'(m_best));
    chk({tag, "_done_MatchCount"}, 32'(MatchCount), 32'(m_cnt));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Diagonal cost: identity is the unique 8-cost assignment
    set_rom(0); rand_seq(60); insert_rand(ident());
    do_reset("por");
    run("diag", 0, 0, -1);
    chk("diag_min8", 32'(MinCost), 8);
    chk("diag_cnt1", 32'(MatchCount), 1);

    // All-zero cost: every permutation ties, count saturates, nothing prunes
    set_rom(1); rand_seq(24);
    do_reset("rst_zero");
    run("zero", 0, 0, -1);
    chk("zero_min0", 32'(MinCost), 0);
    chk("zero_cnt15", 32'(MatchCount), 15);

    // Pruning: identity costs 0, swapping workers 0/1 aborts after worker 0
    set_rom(2); seq.delete(); seq.push_back(ident()); seq.push_back(swap01());
    for (int i = 0; i < 6; i++) seq.push_back(rand_perm());
    do_reset("rst_prune");
    run("prune", 0, 0, -1);
    chk("prune_min0", 32'(MinCost), 0);

    // Engine stalls and spurious perm_valid outside WAIT
    set_rom(0); rand_seq(40); insert_rand(ident());
    do_reset("rst_stall");
    run("stall", 1, 1, -1);
    chk("stall_min8", 32'(MinCost), 8);
    chk("stall_cnt1", 32'(MatchCount), 1);

    // Reset during FETCH of the third permutation, then a clean rerun
    do_reset("rst_pre_mid");
    run("midrst", 0, 0, 2);
    do_reset("rst_after_mid");
    run("rerun1", 0, 0, -1);
    chk("rerun1_min8", 32'(MinCost), 8);
    // Reset while parked in DONE
    do_reset("rst_in_done");
    run("rerun2", 1, 1, -1);
    chk("rerun2_min8", 32'(MinCost), 8);
    chk("rerun2_cnt1", 32'(MatchCount), 1);

    // Tie: identity and the 0/1 swap both cost 20, everything else more
    set_rom(3); rand_seq(40); insert_rand(ident()); insert_rand(swap01());
    do_reset("rst_tie");
    run("tie", 1, 1, -1);
    chk("tie_min20", 32'(MinCost), 20);
    chk("tie_cnt2", 32'(MatchCount), 2);

    set_rom(4); rand_seq(80);
    do_reset("rst_rand");
    run("rand", 1, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jam_ctrl.md
JAM_CTRL -- requirements
Module: jam_ctrl

Interface
REQ-001 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-002 RST  input  1  synchronous, active-high reset.
REQ-003 perm_next  output  1  one-cycle pulse requesting the next permutation from the permutation engine.
REQ-004 perm_valid  input  1  one-cycle pulse; perm_list and perm_last are valid in this cycle only.
REQ-005 perm_list  input  24  job index per worker; bits [3k+2:3k] = job of worker k, k=0..7.
REQ-006 perm_last  input  1  qualified by perm_valid; marks permutation 40320 (7,6,5,4,3,2,1,0).
REQ-007 W  output  3  worker index to cost ROM.
REQ-008 J  output  3  job index to cost ROM.
REQ-009 MatchCost  input  7  cost of (W,J); valid exactly one cycle after W/J are driven (registered ROM).
REQ-010 MinCost  output  10  minimum total assignment cost; valid while Valid=1.
REQ-011 MatchCount  output  4  number of permutations reaching MinCost, saturating at 15.
REQ-012 Valid  output  1  one-cycle pulse when the search completes.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, FETCH, DRAIN, CHECK, DONE.
REQ-014 IDLE: one cycle after reset release -> REQ.
REQ-015 REQ: perm_next=1 for exactly one cycle -> WAIT.
REQ-016 WAIT: hold until perm_valid=1; latch perm_list and perm_last; clear sum and idx; -> FETCH. A perm_valid seen outside WAIT SHALL be ignored.
REQ-017 FETCH: drive W=idx, J=latched job[idx]; idx increments 0..7, one pair per cycle; after idx=7 -> DRAIN.
REQ-018 Accumulate: in each cycle following a FETCH cycle, sum += MatchCost (zero-extended to 10 bits); no overflow (max 8*127=1016).
REQ-019 DRAIN: accumulates the cost of worker 7 -> CHECK.
REQ-020 Pruning: when min_seen=1 and the post-add sum > best, FETCH/DRAIN SHALL abort to CHECK with abort=1; in-flight MatchCost SHALL be discarded.
REQ-021 CHECK, abort=0: if min_seen=0 or sum<best -> best=sum, count=1, min_seen=1; if sum==best -> count=min(count+1,15); if sum>best -> no change.
REQ-022 CHECK exit: latched perm_last=1 -> DONE; otherwise -> REQ.
REQ-023 DONE: Valid=1 in the first DONE cycle only; MinCost/MatchCount hold indefinitely; FSM stays in DONE until RST.
REQ-024 Nominal period per permutation (engine answers in 1 cycle, no prune): REQ+WAIT+8 FETCH+DRAIN+CHECK = 12 cycles.
REQ-025 W/J outside FETCH SHALL hold their last values. perm_next SHALL be 0 outside REQ.

Reset
REQ-026 Reset values: state=IDLE, perm_next=0, W=0, J=0, MinCost=0, MatchCount=0, Valid=0, sum=0, idx=0, min_seen=0, abort=0.
REQ-027 RST asserted in any state, including mid-FETCH or DONE, SHALL restore reset values at the next edge; partial results SHALL be discarded.

Structure
REQ-028 Package jam_pkg SHALL hold NUM_WORK=8, IDX_W=3, COST_W=7, SUM_W=10, CNT_W=4, CNT_MAX=15, and the FSM state enum.
REQ-029 Sub-module jam_cost_acc SHALL contain the sum register, the prune comparator and the best/count update; the FSM stays in jam_ctrl.
REQ-030 Target size: 120-400 lines of RTL; no multipliers; single clock domain.

Verification
REQ-031 Diagonal ROM: cost(w,j)=1 if w==j, else 100; full 40320 run -> MinCost=8, MatchCount=1, exactly one Valid pulse.
REQ-032 All-zero ROM -> MinCost=0, MatchCount=15 (saturated); no pruning occurs.
REQ-033 Pruning: cost(w,j)=127 for j!=w, 0 for j==w; first permutation gives sum 0; the second permutation (1,0 tail swap) aborts after its first nonzero add; check the FETCH cycle count drops below 8.
REQ-034 Engine stall: perm_valid delayed 0-5 random cycles; spurious perm_valid pulses injected outside WAIT -> results identical to REQ-031.
REQ-035 RST pulsed during FETCH of permutation 3 and again during DONE -> all outputs at reset values; rerun gives REQ-031 results.
REQ-036 Tie case: ROM with two distinct permutations of cost 20 and all others >20 -> MinCost=20, MatchCount=2.
